// File: rtl/noc_xy_port_arbiter_if.sv
// rtl/noc_xy_port_arbiter_if.sv - five-port flit handshake bundle for the router crossbar
interface noc_xy_port_arbiter_if #(
   parameter int FW = 10
);
   logic [5*FW-1:0] in_flit;
   logic [4:0]      in_valid;
   logic [4:0]      in_ready;
   logic [5*FW-1:0] out_flit;
   logic [4:0]      out_valid;
   logic [4:0]      out_ready;

   modport slave (
      input  in_flit, in_valid, out_ready,
      output in_ready, out_flit, out_valid
   );

   modport master (
      output in_flit, in_valid, out_ready,
      input  in_ready, out_flit, out_valid
   );
endinterface

// File: rtl/noc_xy_port_arbiter.sv
// rtl/noc_xy_port_arbiter.sv - XY-routed 5-port crossbar scheduler, one flit buffer per input
module noc_xy_port_arbiter #(
   parameter logic [2:0] NODE_ROW = 3'd4,
   parameter logic [2:0] NODE_COL = 3'd4,
   parameter int         FW       = 10
) (
   input logic clk,
   input logic rst,
   noc_xy_port_arbiter_if.slave bus
);
   localparam int NP = 5;
   localparam logic [2:0] P_N = 3'd0;
   localparam logic [2:0] P_S = 3'd1;
   localparam logic [2:0] P_E = 3'd2;
   localparam logic [2:0] P_W = 3'd3;
   localparam logic [2:0] P_L = 3'd4;

   logic [NP-1:0] hold_v;
   logic [FW-1:0] hold_flit [NP];
   logic [NP-1:0] out_valid_q;
   logic [FW-1:0] out_flit_q [NP];
   logic [2:0]    ptr [NP];

   logic [2:0]    route [NP];
   logic [NP-1:0] out_free;
   logic [NP-1:0] cand [NP];
   logic [NP-1:0] gnt_any;
   logic [2:0]    gnt_idx [NP];
   logic [NP-1:0] granted;
   logic [NP-1:0] in_ready_c;

   // Column first, then row: must match the ejector's rule
   function automatic logic [2:0] xy_route(input logic [5:0] addr);
      logic [2:0] row;
      logic [2:0] col;
      row = addr[5:3];
      col = addr[2:0];
      if (col > NODE_COL)      return P_E;
      else if (col < NODE_COL) return P_W;
      else if (row > NODE_ROW) return P_N;
      else if (row < NODE_ROW) return P_S;
      else                     return P_L;
   endfunction

   always_comb begin
      int j;
      j       = 0;
      granted = '0;
      for (int i = 0; i < NP; i++) begin
         route[i] = xy_route(hold_flit[i][5:0]);
      end
      for (int o = 0; o < NP; o++) begin
         out_free[o] = ~out_valid_q[o] | bus.out_ready[o];
         gnt_any[o]  = 1'b0;
         gnt_idx[o]  = 3'd0;
         for (int i = 0; i < NP; i++) begin
            cand[o][i] = hold_v[i] && (route[i] == 3'(o));
         end
         // Round-robin search from ptr[o], wrapping 4 -> 0
         if (out_free[o]) begin
            for (int k = 0; k < NP; k++) begin
               j = int'(ptr[o]) + k;
               if (j >= NP) j = j - NP;
               if (!gnt_any[o] && cand[o][j]) begin
                  gnt_any[o] = 1'b1;
                  gnt_idx[o] = 3'(j);
               end
            end
         end
         if (gnt_any[o]) granted[gnt_idx[o]] = 1'b1;
      end
   end

   // A draining buffer may refill on the same edge for full throughput
   assign in_ready_c   = {NP{~rst}} & (~hold_v | granted);
   assign bus.in_ready  = in_ready_c;
   assign bus.out_valid = out_valid_q;

   for (genvar g = 0; g < NP; g++) begin : g_out
      assign bus.out_flit[g*FW +: FW] = out_flit_q[g];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hold_v      <= '0;
         out_valid_q <= '0;
         for (int i = 0; i < NP; i++) begin
            hold_flit[i]  <= '0;
            out_flit_q[i] <= '0;
            ptr[i]        <= P_N;
         end
      end else begin
         for (int i = 0; i < NP; i++) begin
            if (bus.in_valid[i] && in_ready_c[i]) begin
               hold_flit[i] <= bus.in_flit[i*FW +: FW];
               hold_v[i]    <= 1'b1;
            end else if (granted[i]) begin
               hold_v[i] <= 1'b0;
            end
         end
         for (int o = 0; o < NP; o++) begin
            if (gnt_any[o]) begin
               out_flit_q[o]  <= hold_flit[gnt_idx[o]];
               out_valid_q[o] <= 1'b1;
               ptr[o]         <= (gnt_idx[o] == 3'd4) ? 3'd0 : gnt_idx[o] + 3'd1;
            end else if (bus.out_ready[o]) begin
               out_valid_q[o] <= 1'b0;
            end
         end
      end
   end
endmodule

// File: doc/noc_xy_port_arbiter.md
Name: noc_xy_port_arbiter

Overview:
Crossbar scheduler for a 5-port mesh router node: North, South, East, West and Local.
- Buffers one flit per input port.
- Computes the XY route from the flit's destination address, using the same column-then-row rule as the node's ejector.
- Round-robin arbitrates each output port among the inputs that want it.
- Drives registered outputs with valid/ready back-pressure.
- Sits between the link receivers and the ejector/link drivers of each mesh node.

Parameters:
- NODE_ROW, 3'd4, this node's row coordinate.
- NODE_COL, 3'd4, this node's column coordinate.
- FW, 10, flit width. Address is [5:0] (row=[5:3], col=[2:0]); payload is [FW-1:6].

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_flit  input  5*FW  packed input flits; slice i = port i (0=N, 1=S, 2=E, 3=W, 4=L).
- in_valid  input  5  per-port flit present.
- in_ready  output  5  per-port buffer can accept this cycle.
- out_flit  output  5*FW  packed registered output flits, same port order.
- out_valid  output  5  per-port output register holds a flit.
- out_ready  input  5  downstream accepts out_flit this cycle.

Behaviour:
- Reset: rst sampled high at a clk edge clears all of the following:
  - hold_v[4:0]
  - hold_flit
  - out_valid[4:0]
  - out_flit (all zero)
  - all five round-robin pointers (N highest priority)
- in_ready is 0 while rst is high. A flit mid-transfer at reset is discarded.
- Route per held flit (combinational):
  - col>NODE_COL → E
  - col<NODE_COL → W
  - col==NODE_COL and row>NODE_ROW → N
  - col==NODE_COL and row<NODE_ROW → S
  - row and col both equal → L
  - No U-turn check; the route is used as computed.
- Output slot free: out_free[o] = ~out_valid[o] | out_ready[o].
- Arbitration: for each output o, the candidates are inputs i with hold_v[i] and route(i)==o. If out_free[o], grant one candidate per round-robin.
  - The search starts at ptr[o] and wraps at 4→0.
  - On a grant to i, ptr[o] becomes (i+1) mod 5.
  - ptr[o] does not change when there is no grant.
  - Each input routes to exactly one output, so it receives at most one grant.
- On a grant, at the same edge: out_flit[o] ← hold_flit[i], out_valid[o] ← 1, and input i's buffer is released.
- If out_ready[o]=1 and there is no grant, out_valid[o] ← 0.
- in_ready[i] = ~rst & (~hold_v[i] | granted[i]). The buffer refills in the same cycle it drains, giving full throughput of 1 flit/cycle/port.
- Capture: in_valid[i] & in_ready[i] at an edge loads hold_flit[i] and sets hold_v[i]=1.
- Latency: a flit accepted at edge k is granted earliest at edge k+1, so out_valid is high from edge k+1 onward.
- Back-pressure: while out_ready[o]=0 and out_valid[o]=1:
  - out_flit[o] is held stable;
  - no grant is issued to o;
  - inputs routed to o hold their flits and deassert in_ready.
- Simultaneous events: with 2–5 inputs contending for one output, exactly one grant per cycle. Different outputs grant independently in the same cycle, up to 5 grants total.
- Flits are never dropped, duplicated or reordered within an input→output pair.

Test Plan:
- Reset: hold rst 2 cycles with in_valid=5'h1F → out_valid=0, out_flit=0 and in_ready=0 throughout. First cycle after reset, in_ready=5'h1F.
- Single route: N inputs flit 10'b0000_100_110 (row4, col6) → one cycle after acceptance out_valid[E]=1 with the same flit. Repeat for col2→W, row6/col4→N, row1/col4→S, row4/col4→L.
- Contention: W, S and L all send col6 flits, out_ready all 1 →
  - E outputs S, W, L on consecutive cycles (ptr starts at 0);
  - ptr[E] ends at 0 (wrapped past L);
  - each input's in_ready stays low until its grant.
- Back-pressure: out_ready[E]=0 for 4 cycles with N holding a col7 flit and a second flit pending →
  - out_flit[E] is unchanged;
  - in_ready[N]=0;
  - after release, both flits appear in order on back-to-back cycles.
- Parallel throughput: N→S, S→N, E→W, W→E, L→L streams, in_valid and out_ready held at 1 for 20 cycles → 5 flits/cycle after the first cycle, each stream's payload sequence is preserved, no stalls.
- Reset mid-operation: assert rst while 3 flits are buffered and out_ready=0 → all valids clear on the next edge, and pointers return to N priority (verify with a N/S contention on E: N wins first).
